// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display decoder.
// Segment codes are {a,b,c,d,e,f,g} with a lit segment encoded as 0.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_digit_lut.sv
// Combinational map from one active-low segment pattern to a BCD digit,
// flagging blank and unrecognised patterns.
module seg7_digit_lut
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       is_blank,
    output logic       is_illegal,
    output logic [3:0] digit
);

    always_comb begin
        is_blank   = 1'b0;
        is_illegal = 1'b0;
        digit      = 4'd0;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: is_blank = 1'b1;
            default:   is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_decode.sv
// Four-digit seven-segment word to binary decoder, one digit per cycle, MSB first.
// Define SEG7_DECODE_DP_EN to capture per-digit decimal-point flags on dp.
//
//   state   | meaning
//   IDLE    | waiting for a word, in_ready high
//   DEC     | decoding digit idx (3 down to 0), one per cycle
//   HOLD    | result presented until out_ready
module seg7_decode
    import seg7_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] seg_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [13:0] value,
    output logic        err,
    output logic [3:0]  dp
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

    state_t           state;
    logic [3:0][6:0]  seg_q;
    logic [1:0]       idx;
    logic [13:0]      acc;
    logic             err_q;
    logic             seen_q;

    logic [6:0]       seg_cur;
    logic [6:0]       seg_lut;
    logic             is_blank;
    logic             is_illegal;
    logic [3:0]       digit;
    logic [13:0]      acc_next;

    assign seg_cur = seg_q[idx];
    assign seg_lut = (ACTIVE_LOW != 0) ? seg_cur : ~seg_cur;

    seg7_digit_lut u_lut (
        .seg        (seg_lut),
        .is_blank   (is_blank),
        .is_illegal (is_illegal),
        .digit      (digit)
    );

    // Blank and illegal patterns already map to digit 0 in the LUT; 9999 fits in 14 bits.
    assign acc_next = (acc * 14'd10) + {10'd0, digit};

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state  <= ST_IDLE;
            seg_q  <= '0;
            idx    <= 2'd0;
            acc    <= 14'd0;
            err_q  <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_DIGITS; i++)
                            seg_q[i] <= seg_in[8*i+1 +: 7];
                        acc    <= 14'd0;
                        err_q  <= 1'b0;
                        seen_q <= 1'b0;
                        idx    <= LAST_IDX;
                        state  <= ST_DEC;
                    end
                end
                ST_DEC: begin
                    acc <= acc_next;
                    if (is_blank) begin
                        // Only blanks after a real digit are suspicious; leading blanks are padding.
                        if (seen_q)
                            err_q <= 1'b1;
                    end else begin
                        seen_q <= 1'b1;
                        if (is_illegal)
                            err_q <= 1'b1;
                    end
                    if (idx == 2'd0)
                        state <= ST_HOLD;
                    else
                        idx <= idx - 2'd1;
                end
                ST_HOLD: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);
    assign value     = acc;
    assign err       = err_q;

`ifdef SEG7_DECODE_DP_EN
    logic [3:0] dp_raw_q;
    logic [3:0] dp_q;
    logic       dp_lit;

    assign dp_lit = (ACTIVE_LOW != 0) ? ~dp_raw_q[idx] : dp_raw_q[idx];

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            dp_raw_q <= 4'd0;
            dp_q     <= 4'd0;
        end else begin
            if (state == ST_IDLE && in_valid) begin
                for (int i = 0; i < NUM_DIGITS; i++)
                    dp_raw_q[i] <= seg_in[8*i];
                dp_q <= 4'd0;
            end else if (state == ST_DEC) begin
                dp_q[idx] <= dp_lit;
            end
        end
    end

    assign dp = dp_q;
`else
    logic unused_dp_bits;
    assign unused_dp_bits = ^{seg_in[24], seg_in[16], seg_in[8], seg_in[0]};
    assign dp = 4'd0;
`endif

endmodule

// File: tb/tb_seg7_decode.sv
// Directed self-checking bench for seg7_decode (default ACTIVE_LOW=1).
module tb_seg7_decode;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] seg_in = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [13:0] value;
    logic        err;
    logic [3:0]  dp;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SEG7_DECODE_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    seg7_decode dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seg_in    (seg_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .value     (value),
        .err       (err),
        .dp        (dp)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Offer a word, check N+5 latency, optional stall in HOLD, then release.
    task automatic run_word(input logic [31:0] word, input int exp_val, input bit exp_err,
                            input logic [3:0] exp_dp, input int stall, input bit early_ready);
        in_valid = 1'b1;
        seg_in   = word;
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid  = 1'b0;
        seg_in    = 32'hDEAD_BEEF;
        out_ready = early_ready;
        check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        check("dec_no_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("dec_no_valid", {31'd0, out_valid}, 32'd0);
        end
        tick();
        check("valid_at_n5", {31'd0, out_valid}, 32'd1);
        check("value", {18'd0, value}, 32'(exp_val));
        check("err", {31'd0, err}, {31'd0, exp_err});
        check("dp", {28'd0, dp}, {28'd0, exp_dp});
        if (!early_ready) begin
            for (int k = 0; k < stall; k++) begin
                tick();
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_value", {18'd0, value}, 32'(exp_val));
                check("stall_err", {31'd0, err}, {31'd0, exp_err});
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
        end
        tick();
        out_ready = 1'b0;
        check("ready_after_out", {31'd0, in_ready}, 32'd1);
        check("valid_dropped", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_value", {18'd0, value}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_dp", {28'd0, dp}, 32'd0);
        #19;
        RESET = 1'b1;

        // digits 1,2,3,4; dp bits all unlit (1) in active-low encoding
        run_word(32'h9F25_0D99, 1234, 1'b0, 4'b0000, 0, 1'b0);
        run_word(32'hFFFF_0303, 0,    1'b0, 4'b0000, 0, 1'b0);
        run_word(32'h9FFF_9F9F, 1011, 1'b1, 4'b0000, 10, 1'b0);
        run_word(32'h9F55_9F9F, 1011, 1'b1, 4'b0000, 0, 1'b0);
        run_word(32'hFFFF_FFFF, 0,    1'b0, 4'b0000, 0, 1'b0);
        run_word(32'h0909_0909, 9999, 1'b0, 4'b0000, 0, 1'b1);
        run_word(32'hFF9F_0303, 100,  1'b0, 4'b0000, 2, 1'b0);
        // dp bit cleared (lit) on digits 3 and 1 only
        run_word(32'h9E25_0C99, 1234, 1'b0, DP_EN ? 4'b1010 : 4'b0000, 0, 1'b0);

        // Reset in the second DEC cycle aborts the word immediately.
        in_valid = 1'b1;
        seg_in   = 32'h9F25_0D99;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_dec_partial", {18'd0, value}, 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_value", {18'd0, value}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        RESET = 1'b1;
        run_word(32'h9F25_0D99, 1234, 1'b0, 4'b0000, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
